// File: rtl/cmp_pkg.sv
// Shared types for the cmp4-based statistics stage: sample width and tracker states.
package cmp_pkg;

    localparam int unsigned DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mm_state_t;

endpackage

// File: rtl/cmp4.sv
// 4-bit unsigned magnitude comparator: flags a > b and a < b.
module cmp4
    import cmp_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              Greater,
    output logic              Less
);

    assign Greater = (a > b);
    assign Less    = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Burst statistics: max/min with first-occurrence indices and rising-step count,
// taken over a valid/ready stream of len 4-bit samples.
module minmax_tracker
    import cmp_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic [CNT_W-1:0]  max_idx,
    output logic [CNT_W-1:0]  min_idx,
    output logic [CNT_W-1:0]  rise_cnt
);

    mm_state_t         state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]  max_idx_q, max_idx_d;
    logic [CNT_W-1:0]  min_idx_q, min_idx_d;
    logic [CNT_W-1:0]  rise_q, rise_d;

    logic gt_max, gt_min, gt_prev;
    logic lt_min, lt_max_unused, lt_prev_unused;

    cmp4 u_cmp_max (.a(in_data), .b(max_q),  .Greater(gt_max),  .Less(lt_max_unused));
    cmp4 u_cmp_min (.a(in_data), .b(min_q),  .Greater(gt_min),  .Less(lt_min));
    cmp4 u_cmp_prv (.a(in_data), .b(prev_q), .Greater(gt_prev), .Less(lt_prev_unused));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        min_d     = min_q;
        prev_d    = prev_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        rise_d    = rise_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = len;
                    cnt_d     = '0;
                    max_d     = '0;
                    min_d     = '0;
                    prev_d    = '0;
                    max_idx_d = '0;
                    min_idx_d = '0;
                    rise_d    = '0;
                    state_d   = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (cnt_q == '0) begin
                        max_d = in_data;
                        min_d = in_data;
                    end else begin
                        // Strict compares: ties keep the earliest index.
                        if (gt_max) begin
                            max_d     = in_data;
                            max_idx_d = cnt_q;
                        end
                        if (lt_min) begin
                            min_d     = in_data;
                            min_idx_d = cnt_q;
                        end
                        if (gt_prev) rise_d = rise_q + CNT_W'(1);
                    end
                    prev_d = in_data;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            prev_q    <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            rise_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            min_q     <= min_d;
            prev_q    <= prev_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            rise_q    <= rise_d;
        end
    end

    assign busy     = busy_q;
    assign in_ready = busy_q;
    assign done     = done_q;
    assign max_out  = max_q;
    assign min_out  = min_q;
    assign max_idx  = max_idx_q;
    assign min_idx  = min_idx_q;
    assign rise_cnt = rise_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Self-checking bench for minmax_tracker: queue-based burst model plus directed literal checks.
module tb_minmax_tracker;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic [3:0]       in_data = '0;
    logic             in_ready, busy, done;
    logic [3:0]       max_out, min_out;
    logic [CNT_W-1:0] max_idx, min_idx, rise_cnt;

    minmax_tracker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done),
        .max_out(max_out), .min_out(min_out),
        .max_idx(max_idx), .min_idx(min_idx), .rise_cnt(rise_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting samples, 2 result cycle
    int m_phase = 0;
    int m_len   = 0;
    int q[$];
    int e_max = 0, e_min = 0, e_maxi = 0, e_mini = 0, e_rise = 0;

    function automatic void compute_results();
        e_max = 0; e_min = 0; e_maxi = 0; e_mini = 0; e_rise = 0;
        if (q.size() > 0) begin
            e_max = q[0];
            e_min = q[0];
            for (int i = 1; i < q.size(); i++) begin
                if (q[i] > e_max) begin e_max = q[i]; e_maxi = i; end
                if (q[i] < e_min) begin e_min = q[i]; e_mini = i; end
                if (q[i] > q[i-1]) e_rise++;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_len   = 0;
            q.delete();
            compute_results();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_len = len;
                    q.delete();
                    compute_results();
                    m_phase = (len == 0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    q.push_back(in_data);
                    if (q.size() == m_len) begin
                        compute_results();
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle compare: handshake/status always, results whenever not mid-burst.
    always @(negedge clk) begin
        chk("busy",     busy,     (m_phase == 1));
        chk("in_ready", in_ready, (m_phase == 1));
        chk("done",     done,     (m_phase == 2));
        if (m_phase != 1) begin
            chk("max_out",  max_out,  e_max);
            chk("min_out",  min_out,  e_min);
            chk("max_idx",  max_idx,  e_maxi);
            chk("min_idx",  min_idx,  e_mini);
            chk("rise_cnt", rise_cnt, e_rise);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input int l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = CNT_W'(l);
        @(posedge clk); #1;
        start = 1'b0;
        len   = CNT_W'($urandom);
    endtask

    task automatic send_sample(input logic [3:0] v, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 4'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = v;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        tests++; fails++;
        $display("FAIL handshake_timeout: in_ready never seen, expected 1 (t=%0t)", $time);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        tests++; fails++;
        $display("FAIL %s_done_timeout: done stayed 0, expected 1", name);
    endtask

    task automatic chk_results(input string name, input int mx, input int mxi,
                               input int mn, input int mni, input int rc);
        chk({name, "_max"},  max_out,  mx);
        chk({name, "_maxi"}, max_idx,  mxi);
        chk({name, "_min"},  min_out,  mn);
        chk({name, "_mini"}, min_idx,  mni);
        chk({name, "_rise"}, rise_cnt, rc);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [3:0] basic [5];
        basic = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done",     done,     0);
        chk("rst_max",      max_out,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Basic burst
        do_start(5);
        foreach (basic[i]) send_sample(basic[i], 0);
        wait_done("basic");
        chk_results("basic", 9, 1, 0, 4, 2);
        @(negedge clk);
        chk("basic_done_one_cycle", done, 0);

        // Ties with gaps
        do_start(4);
        for (int i = 0; i < 4; i++) send_sample(4'd7, $urandom_range(0, 3));
        wait_done("ties");
        chk_results("ties", 7, 0, 7, 0, 0);

        // Zero length
        do_start(0);
        chk("zero_done_next", done, 1);
        chk("zero_busy", busy, 0);
        chk_results("zero", 0, 0, 0, 0, 0);

        // Start pulsed mid-burst must be ignored
        do_start(6);
        for (int i = 0; i < 3; i++) send_sample(4'(i + 2), 0);
        start = 1'b1; len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) send_sample(4'(10 - i), 1);
        wait_done("ignstart");
        chk_results("ignstart", 10, 3, 2, 0, 3);

        // Reset mid-burst
        do_start(6);
        send_sample(4'd5, 0);
        send_sample(4'd12, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  busy,     0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_max",   max_out,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_start(3);
        send_sample(4'd4, 0);
        send_sample(4'd6, 2);
        send_sample(4'd2, 0);
        wait_done("after_rst");
        chk_results("after_rst", 6, 1, 2, 2, 1);

        // Full-length wrap
        do_start(255);
        for (int i = 0; i < 255; i++) send_sample(4'(i % 16), 0);
        wait_done("full");
        chk_results("full", 15, 15, 0, 0, 239);
        repeat (6) @(negedge clk);
        chk_results("full_hold", 15, 15, 0, 0, 239);

        // Randomised bursts
        for (int b = 0; b < 30; b++) begin
            int l;
            bit narrow;
            l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
            narrow = ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_start(l);
            for (int i = 0; i < l; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                send_sample(narrow ? 4'($urandom_range(0, 3)) : 4'($urandom),
                            $urandom_range(0, 2));
            end
            wait_done("rand");
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/minmax_tracker.md
# minmax_tracker

Sequential statistics stage downstream of the 4-bit magnitude comparator `cmp4`. It accepts a burst of `len` 4-bit samples over a valid/ready handshake. It uses `cmp4` Greater/Less results to track the burst maximum, minimum, their first-occurrence indices, and the count of strictly rising sample-to-sample steps. Results are presented with a one-cycle `done` pulse and held until the next burst starts.

## Interface
- `CNT_W`, 8, width of `len`, indices and `rise_cnt`; bursts of up to 2^CNT_W−1 samples.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `len`  in  CNT_W  number of samples in the burst; latched with `start`.
- `in_valid`  in  1  sample present on `in_data`.
- `in_ready`  out  1  block accepts a sample; high only in RUN.
- `in_data`  in  4  sample value, unsigned.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse; results valid.
- `max_out`, `min_out`  out  4  burst maximum / minimum.
- `max_idx`, `min_idx`  out  CNT_W  0-based index of the first occurrence.
- `rise_cnt`  out  CNT_W  number of samples strictly greater than the preceding sample.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: `start`=1 and `len`≠0.
  - IDLE→DONE: `start`=1 and `len`=0.
  - RUN→DONE: the handshake that accepts sample number `len`−1.
  - DONE→IDLE: unconditional.
- Accepting `start`:
  - latches `len`;
  - clears `max_out`, `min_out`, both indices, `rise_cnt` and the sample counter to 0.
- Handshake: a sample is accepted on an edge with `in_valid`=1 and `in_ready`=1. `in_valid` may drop at any time; gaps are allowed.
- First sample (index 0): loads `max_out`, `min_out` and the previous-sample register; both indices are 0; no rise is counted.
- Later samples:
  - `cmp4`(sample, max).Greater → replace `max_out` and `max_idx`.
  - `cmp4`(sample, min).Less → replace `min_out` and `min_idx`.
  - `cmp4`(sample, prev).Greater → `rise_cnt`+1.
  - Always update prev.
  - Ties never replace, so indices are the earliest occurrence.
- `start` outside IDLE is ignored. `len` changes outside the start cycle are ignored.
- Result outputs are stable from `done` until the next accepted `start`.
- `rise_cnt` cannot overflow because it is at most `len`−1.
- `rst_n` low at any time, including mid-burst:
  - immediately forces IDLE;
  - all outputs go to 0, including `in_ready`;
  - the partial burst is discarded.

## Timing
- Reset values: every output is 0.
- `start` accepted at edge t: `busy`=`in_ready`=1 from cycle t+1.
- Last sample accepted at edge e:
  - in cycle e+1: `done`=1, `busy`=0, `in_ready`=0, results final;
  - in cycle e+2: back in IDLE.
- `len`=0: `done` is high in the cycle after the `start` edge, with all results 0.
- Earliest re-start is the first IDLE cycle after DONE.
- Minimum burst duration is `len`+1 cycles from the `start` edge to `done`.
- Comparisons are combinational via `cmp4` within the accepting cycle; there are no pipeline bubbles.

## Structure
- Package `cmp_pkg` holds:
  - `localparam DATA_W = 4`;
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mm_state_t`.
- Sub-module: existing `cmp4`, three instances (vs max, vs min, vs prev). Ports: `a`, `b`, `Greater`, `Less`.
- No other hierarchy; counter and registers live in `minmax_tracker`.

## Test plan
- Reset:
  - hold `rst_n`=0 → all outputs 0, `in_ready`=0;
  - release, no `start` → stays idle.
- Basic burst: `len`=5, samples 3,9,1,9,0 back-to-back.
  - Results: `max_out`=9, `max_idx`=1, `min_out`=0, `min_idx`=4, `rise_cnt`=2.
  - `done` is high exactly one cycle, the cycle after the 5th handshake.
- Ties plus backpressure: `len`=4, all samples 7, with `in_valid` gaps of 0–3 cycles.
  - Results: max=min=7, both idx 0, `rise_cnt`=0.
  - `done` only after the 4th accept.
- Zero length: `start` with `len`=0 → `done` in the next cycle, all results 0; `busy` never asserts.
- Control robustness:
  - `start` pulsed during RUN → ignored, burst count unchanged;
  - `rst_n` dropped after 2 of 6 samples → immediate zeros and IDLE;
  - new `start` with `len`=3 then completes correctly.
- Full-length wrap: `len`=255, `in_data` = index mod 16.
  - Results: `max_out`=15, `max_idx`=15, `min_out`=0, `min_idx`=0, `rise_cnt`=239.
  - Results hold until the next `start`.
